alu_control: RTL and testbench

- Registered ALU control decoder for the 32-bit MIPS datapath; sits between the main control unit and the ALU.
- Maps the 3-bit alu_op from the main decoder plus the 6-bit R-type funct field to a 4-bit ALU operation code.
- Also flags HI/LO writes and illegal encodings.
- Output is registered: one clock of latency.

---
 rtl/alu_ctrl_pkg.sv | 57 +++++
 rtl/alu_ctrl_decode.sv | 62 ++++++
 rtl/alu_control.sv | 54 +++++
 tb/tb_alu_control.sv | 118 +++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared encodings for the ALU control decoder: ALU operation
//               codes, alu_op classes from the main decoder and R-type funct
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    typedef logic [3:0] alu_code_t;
    typedef logic [2:0] alu_op_t;
    typedef logic [5:0] funct_t;

    // ALU operation codes
    localparam alu_code_t c_alu_and     = 4'b0000;
    localparam alu_code_t c_alu_or      = 4'b0001;
    localparam alu_code_t c_alu_add     = 4'b0010;
    localparam alu_code_t c_alu_mult    = 4'b0011;
    localparam alu_code_t c_alu_div     = 4'b0100;
    localparam alu_code_t c_alu_sub     = 4'b0110;
    localparam alu_code_t c_alu_slt     = 4'b0111;
    localparam alu_code_t c_alu_mfhi    = 4'b1000;
    localparam alu_code_t c_alu_mflo    = 4'b1001;
    localparam alu_code_t c_alu_sra     = 4'b1011;
    localparam alu_code_t c_alu_nor     = 4'b1100;
    localparam alu_code_t c_alu_sll     = 4'b1101;
    localparam alu_code_t c_alu_srl     = 4'b1110;
    localparam alu_code_t c_alu_illegal = 4'b1111;

    // alu_op classes driven by the main control unit
    localparam alu_op_t c_op_add   = 3'b000;
    localparam alu_op_t c_op_sub   = 3'b001;
    localparam alu_op_t c_op_rtype = 3'b010;
    localparam alu_op_t c_op_and   = 3'b011;
    localparam alu_op_t c_op_or    = 3'b100;
    localparam alu_op_t c_op_slt   = 3'b101;

    // R-type funct field values
    localparam funct_t c_fn_sll  = 6'b000000;
    localparam funct_t c_fn_srl  = 6'b000010;
    localparam funct_t c_fn_sra  = 6'b000011;
    localparam funct_t c_fn_mfhi = 6'b010000;
    localparam funct_t c_fn_mflo = 6'b010010;
    localparam funct_t c_fn_mult = 6'b011000;
    localparam funct_t c_fn_div  = 6'b011010;
    localparam funct_t c_fn_add  = 6'b100000;
    localparam funct_t c_fn_addu = 6'b100001;
    localparam funct_t c_fn_sub  = 6'b100010;
    localparam funct_t c_fn_subu = 6'b100011;
    localparam funct_t c_fn_and  = 6'b100100;
    localparam funct_t c_fn_or   = 6'b100101;
    localparam funct_t c_fn_nor  = 6'b100111;
    localparam funct_t c_fn_slt  = 6'b101010;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational alu_op/funct to ALU-code decoder. Shift funct
//               codes decode only when ALU_CTRL_SHIFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] i_alu_op,
    input  logic [5:0] i_func,
    output logic [3:0] o_alu_ctrl,
    output logic       o_hilo_we,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctrl = c_alu_illegal;
        o_hilo_we  = 1'b0;
        o_illegal  = 1'b1;

        case (i_alu_op)
            c_op_add: begin o_alu_ctrl = c_alu_add; o_illegal = 1'b0; end
            c_op_sub: begin o_alu_ctrl = c_alu_sub; o_illegal = 1'b0; end
            c_op_and: begin o_alu_ctrl = c_alu_and; o_illegal = 1'b0; end
            c_op_or:  begin o_alu_ctrl = c_alu_or;  o_illegal = 1'b0; end
            c_op_slt: begin o_alu_ctrl = c_alu_slt; o_illegal = 1'b0; end
            c_op_rtype: begin
                o_illegal = 1'b0;
                case (i_func)
                    c_fn_add, c_fn_addu: o_alu_ctrl = c_alu_add;
                    c_fn_sub, c_fn_subu: o_alu_ctrl = c_alu_sub;
                    c_fn_and:  o_alu_ctrl = c_alu_and;
                    c_fn_or:   o_alu_ctrl = c_alu_or;
                    c_fn_nor:  o_alu_ctrl = c_alu_nor;
                    c_fn_slt:  o_alu_ctrl = c_alu_slt;
                    c_fn_mfhi: o_alu_ctrl = c_alu_mfhi;
                    c_fn_mflo: o_alu_ctrl = c_alu_mflo;
                    c_fn_mult: begin o_alu_ctrl = c_alu_mult; o_hilo_we = 1'b1; end
                    c_fn_div:  begin o_alu_ctrl = c_alu_div;  o_hilo_we = 1'b1; end
`ifdef ALU_CTRL_SHIFT_EN
                    c_fn_sll:  o_alu_ctrl = c_alu_sll;
                    c_fn_srl:  o_alu_ctrl = c_alu_srl;
                    c_fn_sra:  o_alu_ctrl = c_alu_sra;
`endif
                    // Unknown or X/Z funct resolves to a defined illegal code
                    default: begin
                        o_alu_ctrl = c_alu_illegal;
                        o_illegal  = 1'b1;
                    end
                endcase
            end
            default: begin
                o_alu_ctrl = c_alu_illegal;
                o_illegal  = 1'b1;
            end
        endcase
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_control
// Description : Registered ALU control decoder (one cycle latency) with
//               synchronous active-low reset. Optional macro ALU_CTRL_SHIFT_EN
//               enables SLL/SRL/SRA decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alu_op,
    input  logic [5:0] func,
    output logic [3:0] alu_ctrl,
    output logic       hilo_we,
    output logic       illegal
);

    logic [3:0] w_alu_ctrl;
    logic       w_hilo_we;
    logic       w_illegal;

    logic [3:0] r_alu_ctrl;
    logic       r_hilo_we;
    logic       r_illegal;

    alu_ctrl_decode u_decode (
        .i_alu_op   (alu_op),
        .i_func     (func),
        .o_alu_ctrl (w_alu_ctrl),
        .o_hilo_we  (w_hilo_we),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_ctrl <= c_alu_and;
            r_hilo_we  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_alu_ctrl <= w_alu_ctrl;
            r_hilo_we  <= w_hilo_we;
            r_illegal  <= w_illegal;
        end
    end

    assign alu_ctrl = r_alu_ctrl;
    assign hilo_we  = r_hilo_we;
    assign illegal  = r_illegal;

endmodule : alu_control
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control
// Description : Directed-vector self-checking bench for alu_control; each
//               check compares {alu_ctrl, hilo_we, illegal} one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic [2:0] alu_op;
    logic [5:0] func;
    logic [3:0] alu_ctrl;
    logic       hilo_we;
    logic       illegal;

    int vec_cnt = 0;
    int err_cnt = 0;

    alu_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_op   (alu_op),
        .func     (func),
        .alu_ctrl (alu_ctrl),
        .hilo_we  (hilo_we),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] observed,
                         input logic [5:0] expected);
        vec_cnt++;
        if (observed !== expected) begin
            err_cnt++;
            $display("FAIL %s: got ctrl=%b we=%b ill=%b, expected ctrl=%b we=%b ill=%b",
                     tag, observed[5:2], observed[1], observed[0],
                     expected[5:2], expected[1], expected[0]);
        end
    endtask

    // Drive on the falling edge, then sample 1 ns after the next rising edge
    task automatic step(input string tag, input logic rst_v, input logic [2:0] op,
                        input logic [5:0] fn, input logic [3:0] e_ctrl,
                        input logic e_we, input logic e_ill);
        @(negedge clk);
        rst_n  = rst_v;
        alu_op = op;
        func   = fn;
        @(posedge clk);
        #1;
        check(tag, {alu_ctrl, hilo_we, illegal}, {e_ctrl, e_we, e_ill});
    endtask

    initial begin
        rst_n  = 1'b0;
        alu_op = 3'b010;
        func   = 6'b100010;

        // Reset overrides a SUB decode
        step("rst0", 1'b0, 3'b010, 6'b100010, 4'b0000, 1'b0, 1'b0);
        step("rst1", 1'b0, 3'b010, 6'b100010, 4'b0000, 1'b0, 1'b0);
        step("rel_sub", 1'b1, 3'b010, 6'b100010, 4'b0110, 1'b0, 1'b0);

        // Non-R classes ignore func
        step("op000", 1'b1, 3'b000, 6'b101010, 4'b0010, 1'b0, 1'b0);
        step("op001", 1'b1, 3'b001, 6'b101010, 4'b0110, 1'b0, 1'b0);
        step("op011", 1'b1, 3'b011, 6'b101010, 4'b0000, 1'b0, 1'b0);
        step("op100", 1'b1, 3'b100, 6'b101010, 4'b0001, 1'b0, 1'b0);
        step("op101", 1'b1, 3'b101, 6'b101010, 4'b0111, 1'b0, 1'b0);
        step("op110", 1'b1, 3'b110, 6'b101010, 4'b1111, 1'b0, 1'b1);
        step("op111", 1'b1, 3'b111, 6'b011000, 4'b1111, 1'b0, 1'b1);

        // R-type sweep
        step("r_and",  1'b1, 3'b010, 6'b100100, 4'b0000, 1'b0, 1'b0);
        step("r_or",   1'b1, 3'b010, 6'b100101, 4'b0001, 1'b0, 1'b0);
        step("r_nor",  1'b1, 3'b010, 6'b100111, 4'b1100, 1'b0, 1'b0);
        step("r_add",  1'b1, 3'b010, 6'b100000, 4'b0010, 1'b0, 1'b0);
        step("r_addu", 1'b1, 3'b010, 6'b100001, 4'b0010, 1'b0, 1'b0);
        step("r_subu", 1'b1, 3'b010, 6'b100011, 4'b0110, 1'b0, 1'b0);
        step("r_slt",  1'b1, 3'b010, 6'b101010, 4'b0111, 1'b0, 1'b0);
        step("r_mfhi", 1'b1, 3'b010, 6'b010000, 4'b1000, 1'b0, 1'b0);
        step("r_mflo", 1'b1, 3'b010, 6'b010010, 4'b1001, 1'b0, 1'b0);

        // HI/LO writers, then a non-R op clears hilo_we
        step("r_mult", 1'b1, 3'b010, 6'b011000, 4'b0011, 1'b1, 1'b0);
        step("r_div",  1'b1, 3'b010, 6'b011010, 4'b0100, 1'b1, 1'b0);
        step("we_clr", 1'b1, 3'b000, 6'b011010, 4'b0010, 1'b0, 1'b0);

        // Illegal funct and recovery
        step("r_ill",  1'b1, 3'b010, 6'b111111, 4'b1111, 1'b0, 1'b1);
        step("r_rec",  1'b1, 3'b010, 6'b100000, 4'b0010, 1'b0, 1'b0);

        // Shift encodings
`ifdef ALU_CTRL_SHIFT_EN
        step("r_sll", 1'b1, 3'b010, 6'b000000, 4'b1101, 1'b0, 1'b0);
        step("r_srl", 1'b1, 3'b010, 6'b000010, 4'b1110, 1'b0, 1'b0);
        step("r_sra", 1'b1, 3'b010, 6'b000011, 4'b1011, 1'b0, 1'b0);
`else
        step("r_sll", 1'b1, 3'b010, 6'b000000, 4'b1111, 1'b0, 1'b1);
        step("r_srl", 1'b1, 3'b010, 6'b000010, 4'b1111, 1'b0, 1'b1);
        step("r_sra", 1'b1, 3'b010, 6'b000011, 4'b1111, 1'b0, 1'b1);
`endif

        // Mid-stream reset clears a HI/LO decode
        step("r_mult2", 1'b1, 3'b010, 6'b011000, 4'b0011, 1'b1, 1'b0);
        step("rst_mid", 1'b0, 3'b010, 6'b011000, 4'b0000, 1'b0, 1'b0);
        step("rel_or",  1'b1, 3'b100, 6'b000000, 4'b0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_alu_control
`default_nettype wire
